// File: rtl/mem_bus_arbiter.sv
// Arbiter for the shared 128-bit DRAM bus between the icache line-fill unit and
// the dcache writeback/fill unit. It runs one transaction at a time and routes read data back to the owner.
module mem_bus_arbiter #(
  parameter int TOUT_W = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ic_req,
  input  logic [31:4]   ic_adr,
  output logic          ic_gnt,
  output logic          ic_rdat_valid,
  input  logic          dc_req,
  input  logic          dc_we,
  input  logic [31:4]   dc_adr,
  input  logic [127:0]  dc_wdata,
  input  logic [15:0]   dc_wmask,
  input  logic          dc_lock,
  output logic          dc_gnt,
  output logic          dc_wack,
  output logic          dc_rdat_valid,
  output logic [127:0]  rdat_data,
  output logic          m_req,
  output logic          m_we,
  output logic [31:4]   m_adr,
  output logic [127:0]  m_wdata,
  output logic [15:0]   m_wmask,
  input  logic          m_ack,
  input  logic          m_rdat_valid,
  input  logic [127:0]  m_rdat_data,
  output logic [1:0]    owner,
  output logic          tout_err
);

  typedef enum logic [1:0] {IDLE = 2'd0, CMD = 2'd1, RDWAIT = 2'd2} state_t;

  localparam logic [TOUT_W-1:0] WD_MAX = {TOUT_W{1'b1}};
  localparam logic [TOUT_W-1:0] WD_ONE = {{(TOUT_W-1){1'b0}}, 1'b1};

  state_t              state_r;
  logic                last_dc_r;
  logic                lock_hold_r;
  logic                cmd_lock_r;
  logic [TOUT_W-1:0]   wd_cnt_r;
  logic                ic_gnt_r;
  logic                dc_gnt_r;
  logic                dc_wack_r;
  logic                ic_rv_r;
  logic                dc_rv_r;
  logic [127:0]        rdat_data_r;
  logic                m_req_r;
  logic                m_we_r;
  logic [31:4]         m_adr_r;
  logic [127:0]        m_wdata_r;
  logic [15:0]         m_wmask_r;
  logic [1:0]          owner_r;
  logic                tout_err_r;

  logic                ic_elig_s;
  logic                ic_win_s;
  logic                dc_win_s;
  logic                rd_done_s;
  logic                wd_expired_s;

  // Arbitration among eligible requesters plus completion/timeout decode.
  always_comb begin
    ic_elig_s = ic_req & ~lock_hold_r;
    ic_win_s  = 1'b0;
    dc_win_s  = 1'b0;
    if (dc_req && ic_elig_s) begin
      // On a tie the side that did not own the bus last goes first.
      dc_win_s = ~last_dc_r;
      ic_win_s = last_dc_r;
    end else if (dc_req) begin
      dc_win_s = 1'b1;
    end else if (ic_elig_s) begin
      ic_win_s = 1'b1;
    end else begin
      ic_win_s = 1'b0;
      dc_win_s = 1'b0;
    end
    rd_done_s    = ((state_r == CMD) && m_ack && !m_we_r && m_rdat_valid) ||
                   ((state_r == RDWAIT) && m_rdat_valid);
    wd_expired_s = (wd_cnt_r == WD_MAX);
  end

  // Transaction FSM with registered grants, bus command, completions and watchdog.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      last_dc_r   <= 1'b0;
      lock_hold_r <= 1'b0;
      cmd_lock_r  <= 1'b0;
      wd_cnt_r    <= {TOUT_W{1'b0}};
      ic_gnt_r    <= 1'b0;
      dc_gnt_r    <= 1'b0;
      dc_wack_r   <= 1'b0;
      ic_rv_r     <= 1'b0;
      dc_rv_r     <= 1'b0;
      rdat_data_r <= 128'd0;
      m_req_r     <= 1'b0;
      m_we_r      <= 1'b0;
      m_adr_r     <= 28'd0;
      m_wdata_r   <= 128'd0;
      m_wmask_r   <= 16'd0;
      owner_r     <= 2'b00;
      tout_err_r  <= 1'b0;
    end else begin
      ic_gnt_r  <= 1'b0;
      dc_gnt_r  <= 1'b0;
      dc_wack_r <= 1'b0;
      ic_rv_r   <= 1'b0;
      dc_rv_r   <= 1'b0;
      case (state_r)
        IDLE: begin
          if (ic_win_s || dc_win_s) begin
            state_r    <= CMD;
            wd_cnt_r   <= {TOUT_W{1'b0}};
            m_req_r    <= 1'b1;
            last_dc_r  <= dc_win_s;
            ic_gnt_r   <= ic_win_s;
            dc_gnt_r   <= dc_win_s;
            owner_r    <= dc_win_s ? 2'b10 : 2'b01;
            m_we_r     <= dc_win_s & dc_we;
            m_adr_r    <= dc_win_s ? dc_adr : ic_adr;
            m_wdata_r  <= dc_win_s ? dc_wdata : 128'd0;
            m_wmask_r  <= dc_win_s ? dc_wmask : 16'd0;
            // A lock only means something when it rides on a writeback.
            cmd_lock_r <= dc_win_s & dc_we & dc_lock;
          end else begin
            owner_r <= 2'b00;
          end
        end
        CMD: begin
          wd_cnt_r <= wd_cnt_r + WD_ONE;
          if (wd_expired_s) begin
            tout_err_r  <= 1'b1;
            lock_hold_r <= 1'b0;
            m_req_r     <= 1'b0;
            owner_r     <= 2'b00;
            state_r     <= IDLE;
          end else if (m_ack && m_we_r) begin
            m_req_r     <= 1'b0;
            dc_wack_r   <= 1'b1;
            lock_hold_r <= cmd_lock_r;
            state_r     <= IDLE;
          end else if (rd_done_s) begin
            m_req_r     <= 1'b0;
            ic_rv_r     <= owner_r[0];
            dc_rv_r     <= owner_r[1];
            rdat_data_r <= m_rdat_data;
            lock_hold_r <= lock_hold_r & ~owner_r[1];
            state_r     <= IDLE;
          end else if (m_ack) begin
            m_req_r <= 1'b0;
            state_r <= RDWAIT;
          end else begin
            state_r <= CMD;
          end
        end
        RDWAIT: begin
          wd_cnt_r <= wd_cnt_r + WD_ONE;
          if (wd_expired_s) begin
            tout_err_r  <= 1'b1;
            lock_hold_r <= 1'b0;
            owner_r     <= 2'b00;
            state_r     <= IDLE;
          end else if (rd_done_s) begin
            ic_rv_r     <= owner_r[0];
            dc_rv_r     <= owner_r[1];
            rdat_data_r <= m_rdat_data;
            lock_hold_r <= lock_hold_r & ~owner_r[1];
            state_r     <= IDLE;
          end else begin
            state_r <= RDWAIT;
          end
        end
        default: begin
          m_req_r <= 1'b0;
          owner_r <= 2'b00;
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign ic_gnt        = ic_gnt_r;
  assign dc_gnt        = dc_gnt_r;
  assign dc_wack       = dc_wack_r;
  assign ic_rdat_valid = ic_rv_r;
  assign dc_rdat_valid = dc_rv_r;
  assign rdat_data     = rdat_data_r;
  assign m_req         = m_req_r;
  assign m_we          = m_we_r;
  assign m_adr         = m_adr_r;
  assign m_wdata       = m_wdata_r;
  assign m_wmask       = m_wmask_r;
  assign owner         = owner_r;
  assign tout_err      = tout_err_r;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: directed sequences, a transaction table and
// randomized traffic checked against a transaction-level arbitration model.
module tb_mem_bus_arbiter;
  localparam int TOUT_W = 10;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          ic_req, dc_req, dc_we, dc_lock, m_ack, m_rdat_valid;
  logic [31:4]   ic_adr, dc_adr;
  logic [127:0]  dc_wdata, m_rdat_data;
  logic [15:0]   dc_wmask;
  logic          ic_gnt, ic_rdat_valid, dc_gnt, dc_wack, dc_rdat_valid;
  logic          m_req, m_we, tout_err;
  logic [127:0]  rdat_data, m_wdata;
  logic [31:4]   m_adr;
  logic [15:0]   m_wmask;
  logic [1:0]    owner;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct packed {
    logic       ic;
    logic       dc;
    logic       we;
    logic       lock;
    logic [1:0] win;
  } vec_t;
  vec_t tbl [0:10];

  always #5 clk = ~clk;

  mem_bus_arbiter #(.TOUT_W(TOUT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .ic_req(ic_req), .ic_adr(ic_adr), .ic_gnt(ic_gnt), .ic_rdat_valid(ic_rdat_valid),
    .dc_req(dc_req), .dc_we(dc_we), .dc_adr(dc_adr), .dc_wdata(dc_wdata),
    .dc_wmask(dc_wmask), .dc_lock(dc_lock), .dc_gnt(dc_gnt), .dc_wack(dc_wack),
    .dc_rdat_valid(dc_rdat_valid), .rdat_data(rdat_data),
    .m_req(m_req), .m_we(m_we), .m_adr(m_adr), .m_wdata(m_wdata), .m_wmask(m_wmask),
    .m_ack(m_ack), .m_rdat_valid(m_rdat_valid), .m_rdat_data(m_rdat_data),
    .owner(owner), .tout_err(tout_err)
  );

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0b required %0b at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chkv(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic clear_inputs();
    ic_req = 1'b0; ic_adr = 28'd0; dc_req = 1'b0; dc_we = 1'b0; dc_lock = 1'b0;
    dc_adr = 28'd0; dc_wdata = 128'd0; dc_wmask = 16'd0;
    m_ack = 1'b0; m_rdat_valid = 1'b0; m_rdat_data = 128'd0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 1'b0;
    #1;
    chk1("rst_m_req", m_req, 1'b0);
    chkv("rst_owner", 128'(owner), 128'd0);
    chk1("rst_gnt", ic_gnt | dc_gnt, 1'b0);
    chk1("rst_valids", ic_rdat_valid | dc_rdat_valid | dc_wack, 1'b0);
    chk1("rst_tout", tout_err, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic chk_cmd(input logic we, input logic [27:0] adr, input logic [127:0] wd,
                         input logic [15:0] wm);
    chk1("cmd_m_req", m_req, 1'b1);
    chk1("cmd_m_we", m_we, we);
    chkv("cmd_m_adr", 128'(m_adr), 128'(adr));
    chkv("cmd_m_wmask", 128'(m_wmask), 128'(wm));
    if (we) chkv("cmd_m_wdata", m_wdata, wd);
  endtask

  // Requests are already driven in an IDLE cycle; expect the grant next cycle,
  // play the bus side and check the completion routed to the winner (1=ic, 2=dc).
  task automatic do_txn(input int win, input int ack_dly, input int rd_dly, input logic [127:0] rd);
    logic         exp_we;
    logic [27:0]  exp_adr;
    logic [127:0] exp_wd;
    logic [15:0]  exp_wm;
    @(negedge clk);
    chk1("ic_gnt", ic_gnt, win == 1);
    chk1("dc_gnt", dc_gnt, win == 2);
    chkv("owner", 128'(owner), 128'(win));
    chk1("rv_once", ic_rdat_valid | dc_rdat_valid | dc_wack, 1'b0);
    exp_we  = (win == 2) && dc_we;
    exp_adr = (win == 2) ? dc_adr : ic_adr;
    exp_wd  = dc_wdata;
    exp_wm  = (win == 2) ? dc_wmask : 16'h0000;
    if (win == 1) begin
      ic_req = 1'b0; ic_adr = 28'($urandom);
    end else begin
      dc_req = 1'b0; dc_adr = 28'($urandom); dc_wdata = rnd128();
      dc_wmask = 16'($urandom); dc_we = 1'($urandom); dc_lock = 1'($urandom);
    end
    chk_cmd(exp_we, exp_adr, exp_wd, exp_wm);
    repeat (ack_dly) begin
      @(negedge clk);
      chk1("no_gnt_busy", ic_gnt | dc_gnt, 1'b0);
      chk_cmd(exp_we, exp_adr, exp_wd, exp_wm);
    end
    m_ack = 1'b1;
    if (!exp_we && rd_dly == 0) begin
      m_rdat_valid = 1'b1; m_rdat_data = rd;
    end
    @(negedge clk);
    m_ack = 1'b0; m_rdat_valid = 1'b0; m_rdat_data = rnd128();
    chk1("m_req_off", m_req, 1'b0);
    chk1("no_gnt_ack", ic_gnt | dc_gnt, 1'b0);
    if (exp_we) begin
      chk1("dc_wack", dc_wack, 1'b1);
      chk1("wr_no_rv", ic_rdat_valid | dc_rdat_valid, 1'b0);
    end else begin
      chk1("rd_no_wack", dc_wack, 1'b0);
      if (rd_dly > 0) begin
        chk1("early_rv", ic_rdat_valid | dc_rdat_valid, 1'b0);
        repeat (rd_dly - 1) begin
          @(negedge clk);
          chk1("early_rv", ic_rdat_valid | dc_rdat_valid, 1'b0);
        end
        m_rdat_valid = 1'b1; m_rdat_data = rd;
        @(negedge clk);
        m_rdat_valid = 1'b0; m_rdat_data = rnd128();
      end
      chk1("ic_rv", ic_rdat_valid, win == 1);
      chk1("dc_rv", dc_rdat_valid, win == 2);
      chkv("rdat_data", rdat_data, rd);
    end
  endtask

  initial begin
    int   win;
    logic ic_pend, dc_pend, lock_m, cur_we, cur_lock;
    int   last_m;

    // ic, dc, dc_we, dc_lock, expected winner; state carries from row to row.
    tbl[0]  = '{1'b1, 1'b1, 1'b0, 1'b0, 2'd2};
    tbl[1]  = '{1'b1, 1'b1, 1'b0, 1'b0, 2'd1};
    tbl[2]  = '{1'b0, 1'b1, 1'b1, 1'b1, 2'd2};
    tbl[3]  = '{1'b1, 1'b1, 1'b0, 1'b0, 2'd2};
    tbl[4]  = '{1'b1, 1'b1, 1'b1, 1'b0, 2'd1};
    tbl[5]  = '{1'b1, 1'b0, 1'b0, 1'b0, 2'd1};
    tbl[6]  = '{1'b1, 1'b1, 1'b1, 1'b1, 2'd2};
    tbl[7]  = '{1'b1, 1'b1, 1'b1, 1'b0, 2'd2};
    tbl[8]  = '{1'b1, 1'b1, 1'b0, 1'b0, 2'd1};
    tbl[9]  = '{1'b0, 1'b1, 1'b0, 1'b1, 2'd2};
    tbl[10] = '{1'b1, 1'b1, 1'b0, 1'b0, 2'd1};

    do_reset();

    // Single icache read with exact cycle timing.
    @(negedge clk);
    ic_req = 1'b1; ic_adr = 28'h0000100;
    @(negedge clk);
    chk1("s_gnt", ic_gnt, 1'b1);
    chk1("s_m_req1", m_req, 1'b1);
    chk1("s_m_we", m_we, 1'b0);
    chkv("s_m_adr", 128'(m_adr), 128'h100);
    chkv("s_owner1", 128'(owner), 128'd1);
    ic_req = 1'b0;
    @(negedge clk);
    chk1("s_gnt_pulse", ic_gnt, 1'b0);
    chk1("s_m_req2", m_req, 1'b1);
    @(negedge clk);
    chk1("s_m_req3", m_req, 1'b1);
    m_ack = 1'b1;
    @(negedge clk);
    m_ack = 1'b0;
    chk1("s_m_req4", m_req, 1'b0);
    chkv("s_owner4", 128'(owner), 128'd1);
    @(negedge clk);
    chk1("s_rv5", ic_rdat_valid, 1'b0);
    @(negedge clk);
    chk1("s_rv6", ic_rdat_valid, 1'b0);
    m_rdat_valid = 1'b1; m_rdat_data = {16{8'hA5}};
    @(negedge clk);
    m_rdat_valid = 1'b0; m_rdat_data = 128'd0;
    chk1("s_rv7", ic_rdat_valid, 1'b1);
    chk1("s_dc_rv7", dc_rdat_valid, 1'b0);
    chkv("s_data7", rdat_data, {16{8'hA5}});
    chkv("s_owner7", 128'(owner), 128'd1);
    @(negedge clk);
    chk1("s_rv8", ic_rdat_valid, 1'b0);
    chkv("s_owner8", 128'(owner), 128'd0);

    // Table of back-to-back zero-wait transactions from reset.
    do_reset();
    for (int i = 0; i <= 10; i++) begin
      ic_req = tbl[i].ic; ic_adr = 28'($urandom);
      dc_req = tbl[i].dc; dc_we = tbl[i].we; dc_lock = tbl[i].lock;
      dc_adr = 28'($urandom); dc_wdata = rnd128(); dc_wmask = 16'($urandom);
      do_txn(int'(tbl[i].win), 0, 0, rnd128());
    end

    // Randomized traffic against a transaction-level arbitration model.
    do_reset();
    ic_pend = 1'b0; dc_pend = 1'b0; lock_m = 1'b0; last_m = 1;
    cur_we = 1'b0; cur_lock = 1'b0;
    for (int t = 0; t < 80; t++) begin
      if (!ic_pend && ($urandom_range(1, 0) == 1)) begin
        ic_pend = 1'b1; ic_req = 1'b1; ic_adr = 28'($urandom);
      end
      if (!dc_pend && (($urandom_range(1, 0) == 1) || lock_m || !ic_pend)) begin
        dc_pend = 1'b1; cur_we = 1'($urandom); cur_lock = 1'($urandom);
        dc_req = 1'b1; dc_we = cur_we; dc_lock = cur_lock;
        dc_adr = 28'($urandom); dc_wdata = rnd128(); dc_wmask = 16'($urandom);
      end
      if (ic_pend && !lock_m && dc_pend) win = (last_m == 1) ? 2 : 1;
      else if (dc_pend) win = 2;
      else win = 1;
      do_txn(win, int'($urandom_range(3, 0)), int'($urandom_range(3, 0)), rnd128());
      if (win == 2) begin
        lock_m  = cur_we && cur_lock;
        dc_pend = 1'b0;
      end else begin
        ic_pend = 1'b0;
      end
      last_m = win;
    end

    // Watchdog: icache read never acknowledged.
    do_reset();
    @(negedge clk);
    ic_req = 1'b1; ic_adr = 28'h0ABCDEF;
    @(negedge clk);
    chk1("wd_gnt", ic_gnt, 1'b1);
    ic_req = 1'b0;
    repeat ((1 << TOUT_W) - 1) @(negedge clk);
    chk1("wd_not_yet", tout_err, 1'b0);
    chk1("wd_m_req_held", m_req, 1'b1);
    @(negedge clk);
    chk1("wd_tout", tout_err, 1'b1);
    chkv("wd_owner", 128'(owner), 128'd0);
    chk1("wd_m_req", m_req, 1'b0);
    chk1("wd_no_rv", ic_rdat_valid | dc_rdat_valid, 1'b0);
    dc_req = 1'b1; dc_we = 1'b0; dc_adr = 28'h0001234;
    do_txn(2, 1, 1, rnd128());
    chk1("wd_sticky", tout_err, 1'b1);

    // Asynchronous reset during RDWAIT, then a stray read-valid.
    @(negedge clk);
    ic_req = 1'b1; ic_adr = 28'h0000200;
    @(negedge clk);
    chk1("r_gnt", ic_gnt, 1'b1);
    ic_req = 1'b0; m_ack = 1'b1;
    @(negedge clk);
    m_ack = 1'b0;
    @(negedge clk);
    chkv("r_owner_pre", 128'(owner), 128'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chkv("r_owner", 128'(owner), 128'd0);
    chk1("r_m_req", m_req, 1'b0);
    chk1("r_gnt_off", ic_gnt | dc_gnt, 1'b0);
    chk1("r_tout_clr", tout_err, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    m_rdat_valid = 1'b1; m_rdat_data = rnd128();
    @(negedge clk);
    m_rdat_valid = 1'b0;
    chk1("r_stray1", ic_rdat_valid | dc_rdat_valid, 1'b0);
    @(negedge clk);
    chk1("r_stray2", ic_rdat_valid | dc_rdat_valid, 1'b0);
    chkv("r_owner_idle", 128'(owner), 128'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
